// File: rtl/note_envelope_shaper.sv
// ADSR envelope and master gain applied to a signed tone stream, with a registered
// valid/ready output and a sticky overrun flag. Define NES_SAT_EN to saturate the output instead of wrapping it.
module note_envelope_shaper #(
    parameter int IN_W  = 32,
    parameter int ENV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             gate,
    input  logic             trig,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    input  logic [ENV_W-1:0] attack_step,
    input  logic [ENV_W-1:0] decay_step,
    input  logic [ENV_W-1:0] sustain_level,
    input  logic [ENV_W-1:0] release_step,
    input  logic [3:0]       gain_shift,
    output logic [IN_W-1:0]  out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    output logic [ENV_W-1:0] env_level,
    output logic [2:0]       env_state
);

    localparam int P_W = IN_W + ENV_W + 1;  // in_data * {0,env}
    localparam int G_W = IN_W + 16;         // width the gain shift is evaluated at
    localparam logic [ENV_W-1:0] ENV_MAX = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ATTACK  = 3'd1,
        ST_DECAY   = 3'd2,
        ST_SUSTAIN = 3'd3,
        ST_RELEASE = 3'd4
    } env_state_t;

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [IN_W-1:0]  out_data_q, out_data_d;
    logic             out_valid_q, out_valid_d;
    logic             overrun_q, overrun_d;

    logic [ENV_W:0]   att_sum;
    logic [ENV_W:0]   dec_diff;
    logic [ENV_W:0]   rel_diff;

    // Envelope arithmetic is done one bit wider so carries and borrows are visible before clamping.
    assign att_sum  = {1'b0, env_q} + {1'b0, attack_step};
    assign dec_diff = {1'b0, env_q} - {1'b0, decay_step};
    assign rel_diff = {1'b0, env_q} - {1'b0, release_step};

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        if (!gate && (state_q == ST_ATTACK || state_q == ST_DECAY || state_q == ST_SUSTAIN)) begin
            state_d = ST_RELEASE;
        end else if (gate && trig) begin
            state_d = ST_ATTACK;
        end else if (gate && (state_q == ST_IDLE || state_q == ST_RELEASE)) begin
            state_d = ST_ATTACK;
        end else if (in_valid) begin
            unique case (state_q)
                ST_ATTACK: begin
                    if (attack_step == '0 || att_sum >= {1'b0, ENV_MAX}) begin
                        env_d   = ENV_MAX;
                        state_d = ST_DECAY;
                    end else begin
                        env_d = att_sum[ENV_W-1:0];
                    end
                end
                ST_DECAY: begin
                    if (decay_step == '0 || env_q <= sustain_level || dec_diff[ENV_W]
                        || dec_diff[ENV_W-1:0] <= sustain_level) begin
                        env_d   = sustain_level;
                        state_d = ST_SUSTAIN;
                    end else begin
                        env_d = dec_diff[ENV_W-1:0];
                    end
                end
                ST_RELEASE: begin
                    if (release_step == '0 || rel_diff[ENV_W] || rel_diff[ENV_W-1:0] == '0) begin
                        env_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        env_d = rel_diff[ENV_W-1:0];
                    end
                end
                ST_IDLE:    env_d = '0;
                default:    env_d = env_q;  // SUSTAIN holds the level latched at the end of DECAY
            endcase
        end
    end

    logic [P_W-1:0]  prod;
    logic [IN_W:0]   scaled;
    logic [G_W-1:0]  scaled_ext;
    logic [G_W-1:0]  gained;
    logic [IN_W-1:0] fitted;
    logic            unused_bits;

    // Sign-extended operands make the low P_W bits of the unsigned product the signed product.
    assign prod       = {{(P_W-IN_W){in_data[IN_W-1]}}, in_data} * {{(P_W-ENV_W){1'b0}}, env_q};
    assign scaled     = prod[P_W-1:ENV_W];
    assign scaled_ext = {{(G_W-IN_W-1){scaled[IN_W]}}, scaled};
    assign gained     = scaled_ext << gain_shift;

`ifdef NES_SAT_EN
    logic fits;
    assign fits        = (gained[G_W-1:IN_W-1] == '0) || (gained[G_W-1:IN_W-1] == '1);
    assign fitted      = fits ? gained[IN_W-1:0]
                              : {gained[G_W-1], {(IN_W-1){~gained[G_W-1]}}};
    assign unused_bits = ^prod[ENV_W-1:0];
`else
    assign fitted      = gained[IN_W-1:0];
    assign unused_bits = ^{prod[ENV_W-1:0], gained[G_W-1:IN_W]};
`endif

    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (in_valid && (!out_valid_q || out_ready)) begin
            out_data_d  = fitted;
            out_valid_d = 1'b1;
        end else if (in_valid) begin
            overrun_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            env_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            env_q       <= env_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign env_level = env_q;
    assign env_state = state_q;

endmodule

// File: tb/tb_note_envelope_shaper.sv
// Directed bench for note_envelope_shaper: ADSR stepping, datapath scaling, handshake,
// overrun, async reset and output fit (expectation follows NES_SAT_EN).
module tb_note_envelope_shaper;

    logic        clk;
    logic        rst;
    logic        gate;
    logic        trig;
    logic [31:0] in_data;
    logic        in_valid;
    logic [15:0] attack_step;
    logic [15:0] decay_step;
    logic [15:0] sustain_level;
    logic [15:0] release_step;
    logic [3:0]  gain_shift;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overrun;
    logic [15:0] env_level;
    logic [2:0]  env_state;

    int n_cmp = 0;
    int n_err = 0;

    note_envelope_shaper #(.IN_W(32), .ENV_W(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .gate          (gate),
        .trig          (trig),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .attack_step   (attack_step),
        .decay_step    (decay_step),
        .sustain_level (sustain_level),
        .release_step  (release_step),
        .gain_shift    (gain_shift),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overrun       (overrun),
        .env_level     (env_level),
        .env_state     (env_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(got), got, $signed(exp), exp);
        end
    endtask

    // Leaves the bench 1 time unit after a rising edge, away from the sampling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d);
        in_data  = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic gap();
        for (int i = 0; i < 3; i++) tick();
    endtask

    task automatic step_check(input string tag, input logic [31:0] d,
                              input logic [31:0] exp_out, input logic [15:0] exp_env,
                              input logic [2:0] exp_state);
        send(d);
        check({tag, ".out"}, out_data, exp_out);
        check({tag, ".env"}, {16'd0, env_level}, {16'd0, exp_env});
        check({tag, ".st"}, {29'd0, env_state}, {29'd0, exp_state});
        gap();
    endtask

    initial begin
        rst = 1'b0; gate = 1'b0; trig = 1'b0; in_data = '0; in_valid = 1'b0;
        attack_step = 16'd16384; decay_step = 16'd8192; sustain_level = 16'd32768;
        release_step = 16'd16384; gain_shift = 4'd0; out_ready = 1'b1;
        #12;
        check("rst.out_valid", {31'd0, out_valid}, 32'd0);
        check("rst.out_data", out_data, 32'd0);
        check("rst.env", {16'd0, env_level}, 32'd0);
        check("rst.state", {29'd0, env_state}, 32'd0);
        check("rst.overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b1;
        tick();

        // Attack from 0 in quarter steps, then decay to the sustain floor.
        gate = 1'b1;
        tick();
        check("att.enter", {29'd0, env_state}, 32'd1);
        step_check("att1", 32'd1000, 32'd0,   16'd16384, 3'd1);
        step_check("att2", 32'd1000, 32'd250, 16'd32768, 3'd1);
        check("att2.valid_clr", {31'd0, out_valid}, 32'd0);
        check("att2.hold", out_data, 32'd250);
        step_check("att3", 32'd1000, 32'd500, 16'd49152, 3'd1);
        step_check("att4", 32'd1000, 32'd750, 16'd65535, 3'd2);
        step_check("dec1", 32'd1000, 32'd999, 16'd57343, 3'd2);
        step_check("dec2", 32'd1000, 32'd874, 16'd49151, 3'd2);
        step_check("dec3", 32'd1000, 32'd749, 16'd40959, 3'd2);
        step_check("dec4", 32'd1000, 32'd624, 16'd32768, 3'd3);

        // Sustain holds its latched level even if sustain_level moves.
        sustain_level = 16'd1000;
        for (int i = 0; i < 10; i++) begin
            send(32'd1000);
            gap();
        end
        check("sus.env", {16'd0, env_level}, 32'd32768);
        check("sus.state", {29'd0, env_state}, 32'd3);
        check("sus.out", out_data, 32'd500);

        // Retrigger keeps the current level, then release.
        trig = 1'b1;
        tick();
        trig = 1'b0;
        check("retrig.state", {29'd0, env_state}, 32'd1);
        check("retrig.env", {16'd0, env_level}, 32'd32768);
        gate = 1'b0;
        tick();
        check("rel.enter", {29'd0, env_state}, 32'd4);
        check("rel.enter_env", {16'd0, env_level}, 32'd32768);
        step_check("rel1", 32'hFFFF_FC18, 32'hFFFF_FE0C, 16'd16384, 3'd4);
        step_check("rel2", 32'hFFFF_FC18, 32'hFFFF_FF06, 16'd0,     3'd0);

        // Backpressure: first sample held, second dropped but still steps the envelope.
        gate = 1'b1;
        tick();
        step_check("ovr.att", 32'd1000, 32'd0, 16'd16384, 3'd1);
        out_ready = 1'b0;
        send(32'd2000);
        gap();
        check("ovr.first_valid", {31'd0, out_valid}, 32'd1);
        check("ovr.first_data", out_data, 32'd500);
        check("ovr.none_yet", {31'd0, overrun}, 32'd0);
        send(32'd3000);
        check("ovr.held", out_data, 32'd500);
        check("ovr.flag", {31'd0, overrun}, 32'd1);
        check("ovr.env", {16'd0, env_level}, 32'd49152);
        out_ready = 1'b1;
        tick();
        check("ovr.drain", {31'd0, out_valid}, 32'd0);
        check("ovr.sticky", {31'd0, overrun}, 32'd1);

        // Full-scale input at full envelope with gain.
        step_check("fit.pre", 32'd1000, 32'd750, 16'd65535, 3'd2);
        gain_shift = 4'd4;
        send(32'h7FFF_FFFF);
`ifdef NES_SAT_EN
        check("fit.max", out_data, 32'h7FFF_FFFF);
`else
        check("fit.max", out_data, 32'hFFF7_FFF0);
`endif
        gain_shift = 4'd0;
        gap();

        // Asynchronous reset in the middle of activity.
        in_data  = 32'd5;
        in_valid = 1'b1;
        #2 rst = 1'b0;
        #1;
        check("mrst.out_valid", {31'd0, out_valid}, 32'd0);
        check("mrst.out_data", out_data, 32'd0);
        check("mrst.env", {16'd0, env_level}, 32'd0);
        check("mrst.state", {29'd0, env_state}, 32'd0);
        check("mrst.overrun", {31'd0, overrun}, 32'd0);
        in_valid = 1'b0;
        rst = 1'b1;
        tick();
        check("mrst.restart", {29'd0, env_state}, 32'd1);
        check("mrst.restart_env", {16'd0, env_level}, 32'd0);

        // Zero steps jump straight to the end of their segment.
        attack_step = 16'd0;
        step_check("zatt", 32'd1000, 32'd0, 16'd65535, 3'd2);
        gate = 1'b0;
        tick();
        check("zrel.enter", {29'd0, env_state}, 32'd4);
        release_step = 16'd0;
        step_check("zrel", 32'd1000, 32'd999, 16'd0, 3'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
